video_scale_pipe: RTL and testbench



---
 rtl/video_scale_pipe.sv | 170 +++++++++++++++++
 tb/tb_video_scale_pipe.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/video_scale_pipe.sv
// video_scale_pipe
//   Registered colour-depth conversion and sync alignment between the VIC
//   core RGB/sync outputs and a video encoder. Each channel is scaled as
//   out = min(MAXO, (x*MAXO + bias) / MAXI) and then carried, together with
//   hsync/vsync/active, through PIPE matched register stages.
//
//   Optional ordered dither (when reducing depth) is compiled in with the
//   macro VIDEO_SCALE_DITHER_EN; without it the ROUND bias is always used.
//
// Ports
//   clk_dot4x              pipeline clock
//   rst                    synchronous active-high reset
//   pix_ce                 pixel enable; all stages advance only when 1
//   red_i/green_i/blue_i   input colour, IN_W bits each
//   hsync_i/vsync_i        input syncs, active level HS_POL / VS_POL
//   active_i               input data enable
//   red_o/green_o/blue_o   scaled colour, OUT_W bits each
//   hsync_o/vsync_o        delay-matched syncs, same polarity as the inputs
//   active_o               delay-matched data enable
//
// Enable semantics: there is no back-pressure. A sample is taken on every
// clk_dot4x edge where pix_ce=1; with pix_ce=0 every register holds.
module video_scale_pipe #(
   parameter int IN_W       = 6,
   parameter int OUT_W      = 8,
   parameter int PIPE       = 2,
   parameter int ROUND      = 1,
   parameter int HS_POL     = 0,
   parameter int VS_POL     = 0,
   parameter int BLANK_ZERO = 1
) (
   input  logic             clk_dot4x,
   input  logic             rst,
   input  logic             pix_ce,
   input  logic [IN_W-1:0]  red_i,
   input  logic [IN_W-1:0]  green_i,
   input  logic [IN_W-1:0]  blue_i,
   input  logic             hsync_i,
   input  logic             vsync_i,
   input  logic             active_i,
   output logic [OUT_W-1:0] red_o,
   output logic [OUT_W-1:0] green_o,
   output logic [OUT_W-1:0] blue_o,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             active_o
);

   localparam int MAXI = (1 << IN_W) - 1;
   localparam int MAXO = (1 << OUT_W) - 1;
   // x*MAXO < 2^(IN_W+OUT_W); adding a bias below MAXI needs one more bit,
   // a second spare bit keeps the clamp compare comfortably in range.
   localparam int PW = IN_W + OUT_W + 2;
   localparam logic HS_ACT = (HS_POL != 0);
   localparam logic VS_ACT = (VS_POL != 0);

   function automatic logic [OUT_W-1:0] scale(input logic [IN_W-1:0] x,
                                              input logic [PW-1:0]   bias);
      logic [PW-1:0] num;
      logic [PW-1:0] quo;
      num = PW'(x) * PW'(MAXO) + bias;
      quo = num / PW'(MAXI);
      if (quo > PW'(MAXO)) quo = PW'(MAXO);
      return quo[OUT_W-1:0];
   endfunction

   // Pipeline stages; index PIPE-1 drives the outputs.
   logic [OUT_W-1:0] r_q [PIPE];
   logic [OUT_W-1:0] g_q [PIPE];
   logic [OUT_W-1:0] b_q [PIPE];
   logic             hs_q [PIPE];
   logic             vs_q [PIPE];
   logic             act_q [PIPE];

   // Phase tracking for ordered dither.
   logic px_ph_q, ln_ph_q, fr_ph_q;
   logic px_ph_d, ln_ph_d, fr_ph_d;
   logic hs_prev_act_q, vs_prev_act_q;
   logic hs_edge, vs_edge;
   logic px_cur, ln_cur, fr_cur;

   logic [PW-1:0]    bias;
   logic [OUT_W-1:0] r0_d, g0_d, b0_d;

   always_comb begin
      hs_edge = (hsync_i == HS_ACT) && !hs_prev_act_q;
      vs_edge = (vsync_i == VS_ACT) && !vs_prev_act_q;
      // Phases as seen by the sample entering this cycle: an edge on this
      // very sample already takes effect for it.
      px_cur  = hs_edge ? 1'b0 : px_ph_q;
      ln_cur  = vs_edge ? 1'b0 : (hs_edge ? ~ln_ph_q : ln_ph_q);
      fr_cur  = vs_edge ? ~fr_ph_q : fr_ph_q;
      px_ph_d = active_i ? ~px_cur : px_cur;
      ln_ph_d = ln_cur;
      fr_ph_d = fr_cur;
   end

   always_comb begin
      bias = (ROUND != 0) ? PW'(MAXI / 2) : '0;
`ifdef VIDEO_SCALE_DITHER_EN
      // 2x2 ordered pattern B = {0,2,3,1} in units of floor(MAXI/4);
      // blanked samples keep the plain rounding bias.
      if ((OUT_W < IN_W) && active_i) begin
         case ({ln_cur ^ fr_cur, px_cur})
            2'd0:    bias = '0;
            2'd1:    bias = PW'(2 * (MAXI / 4));
            2'd2:    bias = PW'(3 * (MAXI / 4));
            default: bias = PW'(MAXI / 4);
         endcase
      end
`endif
   end

   always_comb begin
      r0_d = scale(red_i, bias);
      g0_d = scale(green_i, bias);
      b0_d = scale(blue_i, bias);
      if ((BLANK_ZERO != 0) && !active_i) begin
         r0_d = '0;
         g0_d = '0;
         b0_d = '0;
      end
   end

   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         for (int i = 0; i < PIPE; i++) begin
            r_q[i]   <= '0;
            g_q[i]   <= '0;
            b_q[i]   <= '0;
            hs_q[i]  <= ~HS_ACT;
            vs_q[i]  <= ~VS_ACT;
            act_q[i] <= 1'b0;
         end
         px_ph_q       <= 1'b0;
         ln_ph_q       <= 1'b0;
         fr_ph_q       <= 1'b0;
         hs_prev_act_q <= 1'b0;
         vs_prev_act_q <= 1'b0;
      end else if (pix_ce) begin
         r_q[0]   <= r0_d;
         g_q[0]   <= g0_d;
         b_q[0]   <= b0_d;
         hs_q[0]  <= hsync_i;
         vs_q[0]  <= vsync_i;
         act_q[0] <= active_i;
         for (int i = 1; i < PIPE; i++) begin
            r_q[i]   <= r_q[i-1];
            g_q[i]   <= g_q[i-1];
            b_q[i]   <= b_q[i-1];
            hs_q[i]  <= hs_q[i-1];
            vs_q[i]  <= vs_q[i-1];
            act_q[i] <= act_q[i-1];
         end
         px_ph_q       <= px_ph_d;
         ln_ph_q       <= ln_ph_d;
         fr_ph_q       <= fr_ph_d;
         hs_prev_act_q <= (hsync_i == HS_ACT);
         vs_prev_act_q <= (vsync_i == VS_ACT);
      end
   end

   assign red_o    = r_q[PIPE-1];
   assign green_o  = g_q[PIPE-1];
   assign blue_o   = b_q[PIPE-1];
   assign hsync_o  = hs_q[PIPE-1];
   assign vsync_o  = vs_q[PIPE-1];
   assign active_o = act_q[PIPE-1];

endmodule

// File: tb/tb_video_scale_pipe.sv
// Directed bench for video_scale_pipe. Four instances share clock, reset,
// pixel enable and syncs:
//   u_a  6->8, PIPE=2, ROUND=1 (defaults)
//   u_b  6->8, PIPE=1, ROUND=0
//   u_c  6->6, PIPE=3
//   u_d  8->6, PIPE=1, ROUND=1 (dithered when VIDEO_SCALE_DITHER_EN is set)
module tb_video_scale_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pix_ce = 1'b0;
   logic hs_i = 1'b1, vs_i = 1'b1, act_i = 1'b0;
   logic [5:0] a_ri = '0, a_bi = '0;
   logic [7:0] d_ri = '0;

   logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
   logic [5:0] c_r, c_g, c_b, d_r, d_g, d_b;
   logic a_hs, a_vs, a_act, b_hs, b_vs, b_act;
   logic c_hs, c_vs, c_act, d_hs, d_vs, d_act;

   int n_run = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   video_scale_pipe #(.IN_W(6), .OUT_W(8), .PIPE(2), .ROUND(1)) u_a (
      .clk_dot4x(clk), .rst(rst), .pix_ce(pix_ce),
      .red_i(a_ri), .green_i(a_ri), .blue_i(a_bi),
      .hsync_i(hs_i), .vsync_i(vs_i), .active_i(act_i),
      .red_o(a_r), .green_o(a_g), .blue_o(a_b),
      .hsync_o(a_hs), .vsync_o(a_vs), .active_o(a_act));

   video_scale_pipe #(.IN_W(6), .OUT_W(8), .PIPE(1), .ROUND(0)) u_b (
      .clk_dot4x(clk), .rst(rst), .pix_ce(pix_ce),
      .red_i(a_ri), .green_i(a_ri), .blue_i(a_ri),
      .hsync_i(hs_i), .vsync_i(vs_i), .active_i(act_i),
      .red_o(b_r), .green_o(b_g), .blue_o(b_b),
      .hsync_o(b_hs), .vsync_o(b_vs), .active_o(b_act));

   video_scale_pipe #(.IN_W(6), .OUT_W(6), .PIPE(3), .ROUND(1)) u_c (
      .clk_dot4x(clk), .rst(rst), .pix_ce(pix_ce),
      .red_i(a_ri), .green_i(a_ri), .blue_i(a_ri),
      .hsync_i(hs_i), .vsync_i(vs_i), .active_i(act_i),
      .red_o(c_r), .green_o(c_g), .blue_o(c_b),
      .hsync_o(c_hs), .vsync_o(c_vs), .active_o(c_act));

   video_scale_pipe #(.IN_W(8), .OUT_W(6), .PIPE(1), .ROUND(1)) u_d (
      .clk_dot4x(clk), .rst(rst), .pix_ce(pix_ce),
      .red_i(d_ri), .green_i(d_ri), .blue_i(d_ri),
      .hsync_i(hs_i), .vsync_i(vs_i), .active_i(act_i),
      .red_o(d_r), .green_o(d_g), .blue_o(d_b),
      .hsync_o(d_hs), .vsync_o(d_vs), .active_o(d_act));

`ifdef VIDEO_SCALE_DITHER_EN
   localparam bit DITH = 1'b1;
`else
   localparam bit DITH = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One pixel: pix_ce high for a single edge, then three idle clocks.
   task automatic step(input logic hs, input logic vs, input logic act,
                       input logic [5:0] ra, input logic [7:0] rd);
      hs_i = hs; vs_i = vs; act_i = act;
      a_ri = ra; a_bi = 6'd63 - ra; d_ri = rd;
      pix_ce = 1'b1;
      @(posedge clk); #1;
      pix_ce = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   logic [5:0] va  [5] = '{6'd0, 6'd1, 6'd32, 6'd63, 6'd17};
   logic [7:0] ea  [5] = '{8'd0, 8'd4, 8'd130, 8'd255, 8'd69};
   logic [7:0] eab [5] = '{8'd255, 8'd251, 8'd125, 8'd0, 8'd186};
   logic [7:0] eb  [5] = '{8'd0, 8'd4, 8'd129, 8'd255, 8'd68};
   logic [7:0] vd  [5] = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd255};
   logic [5:0] ed  [5] = '{6'd0, 6'd63, 6'd0, 6'd63, 6'd63};

   logic       s_hs  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   logic       s_act [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   logic [5:0] s_r   [5] = '{6'd63, 6'd63, 6'd10, 6'd20, 6'd63};
   logic [7:0] s_ea  [5] = '{8'd0, 8'd0, 8'd40, 8'd81, 8'd0};
   logic [7:0] s_eb  [5] = '{8'd0, 8'd0, 8'd40, 8'd80, 8'd0};

   // Dither walk on u_d: hsync edge at step 2, vsync edge at step 5.
   logic       t_hs  [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   logic       t_vs  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   logic       t_act [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   logic [7:0] t_x   [9] = '{8'd132, 8'd132, 8'd132, 8'd132, 8'd132, 8'd132, 8'd132, 8'd132, 8'd255};
   logic [5:0] t_dth [9] = '{6'd32, 6'd33, 6'd0, 6'd33, 6'd32, 6'd0, 6'd33, 6'd32, 6'd63};
   logic [5:0] t_rnd [9] = '{6'd33, 6'd33, 6'd0, 6'd33, 6'd33, 6'd0, 6'd33, 6'd33, 6'd63};

   initial begin
      // Reset state
      do_reset();
      check("rst_a_red", a_r, 0);
      check("rst_a_act", a_act, 0);
      check("rst_a_hs", a_hs, 1);
      check("rst_a_vs", a_vs, 1);
      check("rst_c_red", c_r, 0);

      // Basic scaling and latency on all instances
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 1'b1, 1'b1, va[k], vd[k]);
         if (k >= 1) begin
            check("a_red", a_r, ea[k-1]);
            check("a_blue", a_b, eab[k-1]);
            check("a_act", a_act, 1);
         end
         check("b_red_trunc", b_r, eb[k]);
         if (k >= 2) check("c_red_equal", c_r, va[k-2]);
         check("d_red_endpt", d_r, ed[k]);
      end

      // pix_ce held low: everything holds
      repeat (10) @(posedge clk);
      #1;
      check("hold_a_red", a_r, 255);
      check("hold_a_act", a_act, 1);
      check("hold_b_red", b_r, 68);
      check("hold_c_red", c_r, 32);
      step(1'b1, 1'b1, 1'b1, 6'd5, 8'd0);
      check("resume_a_red", a_r, 69);
      check("resume_b_red", b_r, 20);
      check("resume_c_red", c_r, 63);
      step(1'b1, 1'b1, 1'b1, 6'd5, 8'd0);
      check("resume2_a_red", a_r, 20);

      // Equal widths: every value passes through unchanged, 2 pulses late
      for (int i = 0; i < 66; i++) begin
         step(1'b1, 1'b1, 1'b1, 6'(i), 8'd0);
         if (i >= 2) check("c_pass", c_r, i - 2);
      end

      // Sync/colour alignment and blanking
      for (int k = 0; k < 5; k++) begin
         step(s_hs[k], 1'b1, s_act[k], s_r[k], 8'd0);
         if (k >= 1) begin
            check("al_a_hs", a_hs, s_hs[k-1]);
            check("al_a_act", a_act, s_act[k-1]);
            check("al_a_red", a_r, s_ea[k-1]);
         end
         check("al_b_hs", b_hs, s_hs[k]);
         check("al_b_act", b_act, s_act[k]);
         check("al_b_red", b_r, s_eb[k]);
      end

      // Reset mid-line with pix_ce=1
      step(1'b1, 1'b1, 1'b1, 6'd63, 8'd0);
      rst = 1'b1; pix_ce = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; pix_ce = 1'b0;
      check("mid_a_red", a_r, 0);
      check("mid_a_act", a_act, 0);
      check("mid_a_hs", a_hs, 1);
      check("mid_a_vs", a_vs, 1);
      check("mid_b_red", b_r, 0);
      check("mid_c_red", c_r, 0);
      step(1'b1, 1'b1, 1'b1, 6'd32, 8'd0);
      check("post_a_red", a_r, 0);
      check("post_a_act", a_act, 0);
      check("post_b_red", b_r, 129);
      step(1'b1, 1'b1, 1'b1, 6'd32, 8'd0);
      check("post2_a_red", a_r, 130);
      check("post2_a_act", a_act, 1);

      // Depth reduction, with or without ordered dither
      do_reset();
      for (int k = 0; k < 9; k++) begin
         step(t_hs[k], t_vs[k], t_act[k], 6'd0, t_x[k]);
         check("d_red", d_r, DITH ? t_dth[k] : t_rnd[k]);
         check("d_vs", d_vs, t_vs[k]);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
